ipdom_split_join_ctrl: RTL

Control stage directly upstream of the per-warp IPDOM stack: accepts divergent-split and join requests from the warp control path and drives the stack's push/pop, data, read pointer and warp id. It converts stack read-back into join responses for the warp scheduler: a thread-mask restore, or a switch to the else-path with a PC. Split and join ops are serialized, one per cycle at most. A join has a fixed one-cycle response latency.

---
 rtl/ipdom_split_join_ctrl_pkg.sv | 33 +++
 rtl/ipdom_join_fsm.sv | 104 ++++++++++
 rtl/ipdom_split_join_ctrl.sv | 183 ++++++++++++++++++
 3 files changed

// File: rtl/ipdom_split_join_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// ipdom_split_join_ctrl_pkg
// Shared definitions for the IPDOM split/join control stage.
//   log2up()             : ceil(log2(n)), never below 1
//   *_DFLT               : default geometry of the stage and the stack
//   NW_WIDTH             : warp id width for the default warp count
//   ipdom_entry_t        : one stack half-entry, {tmask, pc}
//   ipdom_join_state_e   : join sequencer states
// ---------------------------------------------------------------------------
package ipdom_split_join_ctrl_pkg;

  function automatic int log2up(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int NUM_WARPS_DFLT   = 4;
  localparam int NUM_THREADS_DFLT = 4;
  localparam int PC_WIDTH_DFLT    = 32;
  localparam int DEPTH_DFLT       = 8;

  localparam int NW_WIDTH = log2up(NUM_WARPS_DFLT);

  typedef struct packed {
    logic [NUM_THREADS_DFLT-1:0] tmask;
    logic [PC_WIDTH_DFLT-1:0]    pc;
  } ipdom_entry_t;

  typedef enum logic {
    ST_IDLE      = 1'b0,
    ST_JOIN_WAIT = 1'b1
  } ipdom_join_state_e;

endpackage

// File: rtl/ipdom_join_fsm.sv
// ---------------------------------------------------------------------------
// ipdom_join_fsm
// Join sequencer: holds the IDLE / JOIN_WAIT state, latches the accepted
// join's warp id, read pointer and nop flag, and formats the one-cycle join
// response from the stack read-back.
//
//   state      | meaning
//   -----------+--------------------------------------------------------
//   ST_IDLE    | ops may be accepted; no response pending
//   ST_JOIN_WAIT | join accepted last cycle; stack data valid, respond now
//
// Ports
//   clk, reset        : clock, synchronous active-high reset
//   i_join_fire       : join handshake this cycle
//   i_join_wid        : warp of the accepted join
//   i_join_rd_ptr     : stack slot read for the accepted join
//   i_join_nop        : accepted join has no stack effect
//   i_stk_q_val/idx   : stack read-back ({tmask, pc}, half selector)
//   o_busy            : FSM is in JOIN_WAIT
//   o_wid, o_rd_ptr   : latched warp / read pointer of the pending join
//   o_rsp_*           : join response to the warp scheduler
// ---------------------------------------------------------------------------
module ipdom_join_fsm
  import ipdom_split_join_ctrl_pkg::*;
#(
  parameter int NT   = 4,
  parameter int PCW  = 32,
  parameter int NW_W = 2,
  parameter int AW   = 3
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            i_join_fire,
  input  logic [NW_W-1:0] i_join_wid,
  input  logic [AW-1:0]   i_join_rd_ptr,
  input  logic            i_join_nop,
  input  logic [NT+PCW-1:0] i_stk_q_val,
  input  logic            i_stk_q_idx,
  output logic            o_busy,
  output logic [NW_W-1:0] o_wid,
  output logic [AW-1:0]   o_rd_ptr,
  output logic            o_rsp_valid,
  output logic [NW_W-1:0] o_rsp_wid,
  output logic [NT-1:0]   o_rsp_tmask,
  output logic [PCW-1:0]  o_rsp_pc,
  output logic            o_rsp_pc_set,
  output logic            o_rsp_nop
);

  ipdom_join_state_e r_state;
  logic [NW_W-1:0]   r_wid;
  logic [AW-1:0]     r_rd_ptr;
  logic              r_nop;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= ST_IDLE;
      r_wid    <= '0;
      r_rd_ptr <= '0;
      r_nop    <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (i_join_fire) begin
            r_wid    <= i_join_wid;
            r_rd_ptr <= i_join_rd_ptr;
            r_nop    <= i_join_nop;
            r_state  <= ST_JOIN_WAIT;
          end
        end
        ST_JOIN_WAIT: r_state <= ST_IDLE;
        default:      r_state <= ST_IDLE;
      endcase
    end
  end

  assign o_busy   = (r_state == ST_JOIN_WAIT);
  assign o_wid    = r_wid;
  assign o_rd_ptr = r_rd_ptr;

  // The stack returns the read entry one cycle after the read pointer, so
  // the response is formed from live read-back while in JOIN_WAIT. The
  // reset term drops a response that would coincide with a reset cycle.
  always_comb begin
    o_rsp_valid  = 1'b0;
    o_rsp_wid    = '0;
    o_rsp_tmask  = '0;
    o_rsp_pc     = '0;
    o_rsp_pc_set = 1'b0;
    o_rsp_nop    = 1'b0;
    if (o_busy && !reset) begin
      o_rsp_valid = 1'b1;
      o_rsp_wid   = r_wid;
      o_rsp_nop   = r_nop;
      if (!r_nop) begin
        o_rsp_tmask  = i_stk_q_val[PCW +: NT];
        o_rsp_pc     = i_stk_q_val[PCW-1:0];
        // half 0 holds the else path (first join), half 1 the original mask
        o_rsp_pc_set = ~i_stk_q_idx;
      end
    end
  end

endmodule

// File: rtl/ipdom_split_join_ctrl.sv
// ---------------------------------------------------------------------------
// ipdom_split_join_ctrl
// Control stage in front of the per-warp IPDOM stack. Accepts split and join
// requests (split wins), drives stack push/pop/data/read pointer/warp id,
// and returns join responses (else-path switch or mask restore).
//
// Optional feature: define IPDOM_PERF_EN to build the perf_splits /
// perf_joins counters; otherwise both outputs are tied to zero.
//
// Ports
//   clk, reset            : clock, synchronous active-high reset
//   i_split_*, o_split_*  : split request handshake, o_split_sptr token
//   i_join_*, o_join_*    : join request handshake and response
//   o_stk_*               : stack command (wid, push, pop, rd_ptr, d0, d1)
//   i_stk_*               : stack status and read-back
//   o_err_underflow       : sticky, pop requested on an empty stack
//   o_perf_splits/joins   : event counters (IPDOM_PERF_EN only)
// ---------------------------------------------------------------------------
module ipdom_split_join_ctrl
  import ipdom_split_join_ctrl_pkg::*;
#(
  parameter int NUM_WARPS   = NUM_WARPS_DFLT,
  parameter int NUM_THREADS = NUM_THREADS_DFLT,
  parameter int PC_WIDTH    = PC_WIDTH_DFLT,
  parameter int DEPTH       = DEPTH_DFLT,
  localparam int NW_W       = log2up(NUM_WARPS),
  localparam int AW         = log2up(DEPTH),
  localparam int EW         = NUM_THREADS + PC_WIDTH
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    i_split_valid,
  output logic                    o_split_ready,
  input  logic [NW_W-1:0]         i_split_wid,
  input  logic                    i_split_is_div,
  input  logic [NUM_THREADS-1:0]  i_split_orig_tmask,
  input  logic [NUM_THREADS-1:0]  i_split_else_tmask,
  input  logic [PC_WIDTH-1:0]     i_split_else_pc,
  output logic [AW-1:0]           o_split_sptr,
  input  logic                    i_join_valid,
  output logic                    o_join_ready,
  input  logic [NW_W-1:0]         i_join_wid,
  input  logic [AW-1:0]           i_join_sptr,
  output logic                    o_join_rsp_valid,
  output logic [NW_W-1:0]         o_join_rsp_wid,
  output logic [NUM_THREADS-1:0]  o_join_rsp_tmask,
  output logic [PC_WIDTH-1:0]     o_join_rsp_pc,
  output logic                    o_join_rsp_pc_set,
  output logic                    o_join_rsp_nop,
  output logic [NW_W-1:0]         o_stk_wid,
  output logic                    o_stk_push,
  output logic                    o_stk_pop,
  output logic [AW-1:0]           o_stk_rd_ptr,
  output logic [EW-1:0]           o_stk_d0,
  output logic [EW-1:0]           o_stk_d1,
  input  logic [EW-1:0]           i_stk_q_val,
  input  logic                    i_stk_q_idx,
  input  logic [NUM_WARPS*AW-1:0] i_stk_wr_ptr,
  input  logic                    i_stk_full,
  input  logic                    i_stk_empty,
  output logic                    o_err_underflow,
  output logic [31:0]             o_perf_splits,
  output logic [31:0]             o_perf_joins
);

  logic            w_busy;
  logic            w_idle;
  logic [AW-1:0]   w_wr_ptr [NUM_WARPS];
  logic [AW-1:0]   w_split_ptr;
  logic [AW-1:0]   w_join_ptr;
  logic [AW-1:0]   w_top;
  logic            w_split_fire;
  logic            w_push;
  logic            w_join_fire;
  logic            w_join_hit;
  logic            w_join_nop;
  logic            w_pop;
  logic            w_underflow;
  logic [NW_W-1:0] w_fsm_wid;
  logic [AW-1:0]   w_fsm_rd_ptr;
  logic            r_err_underflow;

  for (genvar g = 0; g < NUM_WARPS; g++) begin : g_wr_ptr
    assign w_wr_ptr[g] = i_stk_wr_ptr[g*AW +: AW];
  end

  // Outputs are gated by reset so the stack sees a quiet interface while
  // the FSM register is being cleared.
  assign w_idle      = ~reset & ~w_busy;
  assign w_split_ptr = w_wr_ptr[i_split_wid];
  assign w_join_ptr  = w_wr_ptr[i_join_wid];
  assign w_top       = w_join_ptr - AW'(1);

  // split path
  assign o_split_ready = w_idle & ~(i_split_is_div & i_stk_full);
  assign w_split_fire  = i_split_valid & o_split_ready;
  assign w_push        = w_split_fire & i_split_is_div;
  assign o_split_sptr  = w_idle ? w_split_ptr : '0;
  assign o_stk_push    = w_push;
  assign o_stk_d1      = w_push ? {i_split_else_tmask, i_split_else_pc} : '0;
  assign o_stk_d0      = w_push ? {i_split_orig_tmask, PC_WIDTH'(0)}    : '0;

  // join path; a pending split blocks joins so at most one op per cycle
  assign o_join_ready = w_idle & ~i_split_valid;
  assign w_join_fire  = i_join_valid & o_join_ready;
  // token equal to the current write pointer means the split never pushed
  assign w_join_hit   = (w_join_ptr != i_join_sptr);
  assign w_pop        = w_join_fire & w_join_hit & ~i_stk_empty;
  assign w_underflow  = w_join_fire & w_join_hit &  i_stk_empty;
  // an underflowing join is suppressed, so it also has no stack effect
  assign w_join_nop   = ~w_join_hit | i_stk_empty;
  assign o_stk_pop    = w_pop;

  always_comb begin
    o_stk_wid    = '0;
    o_stk_rd_ptr = '0;
    if (w_idle) begin
      o_stk_wid    = i_split_valid ? i_split_wid : i_join_wid;
      o_stk_rd_ptr = w_top;
    end else if (!reset) begin
      // hold the read address through JOIN_WAIT while the read-back is used
      o_stk_wid    = w_fsm_wid;
      o_stk_rd_ptr = w_fsm_rd_ptr;
    end
  end

  always_ff @(posedge clk) begin
    if (reset)
      r_err_underflow <= 1'b0;
    else if (w_underflow)
      r_err_underflow <= 1'b1;
  end
  assign o_err_underflow = r_err_underflow;

  ipdom_join_fsm #(
    .NT   (NUM_THREADS),
    .PCW  (PC_WIDTH),
    .NW_W (NW_W),
    .AW   (AW)
  ) u_join_fsm (
    .clk          (clk),
    .reset        (reset),
    .i_join_fire  (w_join_fire),
    .i_join_wid   (i_join_wid),
    .i_join_rd_ptr(w_top),
    .i_join_nop   (w_join_nop),
    .i_stk_q_val  (i_stk_q_val),
    .i_stk_q_idx  (i_stk_q_idx),
    .o_busy       (w_busy),
    .o_wid        (w_fsm_wid),
    .o_rd_ptr     (w_fsm_rd_ptr),
    .o_rsp_valid  (o_join_rsp_valid),
    .o_rsp_wid    (o_join_rsp_wid),
    .o_rsp_tmask  (o_join_rsp_tmask),
    .o_rsp_pc     (o_join_rsp_pc),
    .o_rsp_pc_set (o_join_rsp_pc_set),
    .o_rsp_nop    (o_join_rsp_nop)
  );

`ifdef IPDOM_PERF_EN
  logic [31:0] r_perf_splits;
  logic [31:0] r_perf_joins;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_perf_splits <= '0;
      r_perf_joins  <= '0;
    end else begin
      if (w_push)
        r_perf_splits <= r_perf_splits + 32'd1;
      if (o_join_rsp_valid && !o_join_rsp_nop)
        r_perf_joins  <= r_perf_joins + 32'd1;
    end
  end

  assign o_perf_splits = r_perf_splits;
  assign o_perf_joins  = r_perf_joins;
`else
  assign o_perf_splits = '0;
  assign o_perf_joins  = '0;
`endif

endmodule
